// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, funct3 constants and the decoded bundle shared by the RV64IM decode stage
package decode_pkg;
   typedef enum logic [6:0] {
      OPC_OP        = 7'b0110011,
      OPC_OP_IMM    = 7'b0010011,
      OPC_OP_32     = 7'b0111011,
      OPC_OP_IMM_32 = 7'b0011011,
      OPC_LOAD      = 7'b0000011,
      OPC_STORE     = 7'b0100011,
      OPC_BRANCH    = 7'b1100011,
      OPC_JAL       = 7'b1101111,
      OPC_JALR      = 7'b1100111,
      OPC_LUI       = 7'b0110111,
      OPC_AUIPC     = 7'b0010111
   } opcode_e;
   localparam logic [2:0] F3OP_ADD_SUB = 3'b000, F3OP_SLL = 3'b001, F3OP_SLT = 3'b010, F3OP_SLTU = 3'b011;
   localparam logic [2:0] F3OP_XOR = 3'b100, F3OP_SRL_SRA = 3'b101, F3OP_OR = 3'b110, F3OP_AND = 3'b111;
   localparam logic [2:0] F3M_MUL = 3'b000, F3M_MULH = 3'b001, F3M_MULHSU = 3'b010, F3M_MULHU = 3'b011;
   localparam logic [2:0] F3M_DIV = 3'b100, F3M_DIVU = 3'b101, F3M_REM = 3'b110, F3M_REMU = 3'b111;
   localparam logic [2:0] F3B_BEQ = 3'b000, F3B_BNE = 3'b001, F3B_BLT = 3'b100;
   localparam logic [2:0] F3B_BGE = 3'b101, F3B_BLTU = 3'b110, F3B_BGEU = 3'b111;
   localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;
   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] imm;
      logic [6:0]  op;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        width_32;
      logic        use_imm;
      logic        is_load;
      logic        is_store;
      logic        is_jump;
      logic        is_branch;
      logic        add_operation;
      logic        illegal;
   } decode_bundle_t;
endpackage

// File: rtl/decode_stage_skid_buffer.sv
// skid_buffer: 2-entry registered valid/ready FIFO; in_ready comes only from the entry count
module skid_buffer #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic [1:0]   count_q, count_d;
   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic         push, pop;
   assign in_ready  = count_q != 2'(DEPTH);
   assign out_valid = count_q != 2'd0;
   assign out_data  = head_q;
   always_comb begin
      push    = in_valid && in_ready && !flush;
      pop     = out_valid && out_ready;
      count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
      head_d  = (pop || count_q == 2'd0) ? (count_q == 2'd2 ? tail_q : (push ? in_data : head_q)) : head_q;
      tail_d  = (push && !pop && count_q == 2'd1) ? in_data : tail_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV64IM decode into a 2-entry skid buffer; DECODE_M_EXT_EN enables the M-extension encodings
module decode_stage
   import decode_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [63:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [63:0] imm,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [6:0]  op,
   output logic        width_32,
   output logic        use_imm,
   output logic        is_load,
   output logic        is_store,
   output logic        is_jump,
   output logic        is_branch,
   output logic        add_operation,
   output logic        illegal
);
`ifdef DECODE_M_EXT_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif
   decode_bundle_t d, q;
   opcode_e        opc;
   logic [2:0]     f3;
   logic [6:0]     f7;
   logic           shift, legal;
   logic [63:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = {{52{in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b = {{52{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
   assign imm_j = {{44{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
   always_comb begin
      opc      = opcode_e'(in_inst[6:0]);
      f3       = in_inst[14:12];
      f7       = in_inst[31:25];
      shift    = f3 == F3OP_SLL || f3 == F3OP_SRL_SRA;
      legal    = 1'b1;
      d        = '0;
      d.pc     = in_pc;
      d.op     = in_inst[6:0];
      d.funct3 = f3;
      d.rs1    = in_inst[19:15];
      d.rs2    = in_inst[24:20];
      d.rd     = in_inst[11:7];
      case (opc)
         OPC_OP: begin
            d.funct7 = f7;
            legal    = f7 == F7_BASE || (f7 == F7_ALT && f3 inside {F3OP_ADD_SUB, F3OP_SRL_SRA}) || (M_EN && f7 == F7_MULDIV);
         end
         OPC_OP_32: begin
            d.funct7   = f7;
            d.width_32 = 1'b1;
            legal      = (f7 == F7_BASE && f3 inside {F3OP_ADD_SUB, F3OP_SLL, F3OP_SRL_SRA})
                      || (f7 == F7_ALT && f3 inside {F3OP_ADD_SUB, F3OP_SRL_SRA})
                      || (M_EN && f7 == F7_MULDIV && f3 inside {F3M_MUL, F3M_DIV, F3M_DIVU, F3M_REM, F3M_REMU});
         end
         OPC_OP_IMM: begin
            d.rs2     = '0;
            d.use_imm = 1'b1;
            d.funct7  = shift ? {1'b0, in_inst[30], 5'b0} : 7'b0;
            d.imm     = shift ? {58'b0, in_inst[25:20]} : imm_i;
            legal     = !shift || in_inst[31:26] == 6'b0 || (f3 == F3OP_SRL_SRA && in_inst[31:26] == 6'b010000);
         end
         OPC_OP_IMM_32: begin
            d.rs2      = '0;
            d.use_imm  = 1'b1;
            d.width_32 = 1'b1;
            d.funct7   = shift ? {1'b0, in_inst[30], 5'b0} : 7'b0;
            d.imm      = shift ? {59'b0, in_inst[24:20]} : imm_i;
            legal      = f3 == F3OP_ADD_SUB || (shift && (f7 == F7_BASE || (f3 == F3OP_SRL_SRA && f7 == F7_ALT)));
         end
         OPC_LOAD: begin
            d.rs2     = '0;
            d.is_load = 1'b1;
            d.use_imm = 1'b1;
            d.imm     = imm_i;
            legal     = f3 != 3'b111;
         end
         OPC_STORE: begin
            d.rd       = '0;
            d.is_store = 1'b1;
            d.use_imm  = 1'b1;
            d.imm      = imm_s;
            legal      = !f3[2];
         end
         OPC_BRANCH: begin
            d.rd        = '0;
            d.is_branch = 1'b1;
            d.imm       = imm_b;
            legal       = f3 inside {F3B_BEQ, F3B_BNE, F3B_BLT, F3B_BGE, F3B_BLTU, F3B_BGEU};
         end
         OPC_JAL: begin
            d.rs1     = '0;
            d.rs2     = '0;
            d.is_jump = 1'b1;
            d.imm     = imm_j;
         end
         OPC_JALR: begin
            d.rs2     = '0;
            d.is_jump = 1'b1;
            d.use_imm = 1'b1;
            d.imm     = imm_i;
            legal     = f3 == 3'b000;
         end
         OPC_LUI, OPC_AUIPC: begin
            d.rs1           = '0;
            d.rs2           = '0;
            d.use_imm       = 1'b1;
            d.add_operation = 1'b1;
            d.imm           = imm_u;
         end
         default: legal = 1'b0;
      endcase
      // a trap only needs the PC and opcode; everything else is cleared
      if (!legal) begin
         d         = '0;
         d.pc      = in_pc;
         d.op      = in_inst[6:0];
         d.illegal = 1'b1;
      end
   end
   skid_buffer #(.W($bits(decode_bundle_t)), .DEPTH(DEPTH)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (q)
   );
   assign out_pc        = q.pc;
   assign rs1           = q.rs1;
   assign rs2           = q.rs2;
   assign rd            = q.rd;
   assign imm           = q.imm;
   assign funct3        = q.funct3;
   assign funct7        = q.funct7;
   assign op            = q.op;
   assign width_32      = q.width_32;
   assign use_imm       = q.use_imm;
   assign is_load       = q.is_load;
   assign is_store      = q.is_store;
   assign is_jump       = q.is_jump;
   assign is_branch     = q.is_branch;
   assign add_operation = q.add_operation;
   assign illegal       = q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage; expectations follow DECODE_M_EXT_EN
module tb_decode_stage;
   import decode_pkg::*;
   logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [31:0] in_inst = '0;
   logic [63:0] in_pc = '0;
   logic        in_ready, out_valid, width_32, use_imm, is_load, is_store, is_jump, is_branch, add_operation, illegal;
   logic [63:0] out_pc, imm;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic [6:0]  funct7, op;
   int n_checks = 0, n_fail = 0, pops = 0, p0;
   decode_bundle_t sb[$];
   decode_bundle_t act;
   always #5 clk = ~clk;
   decode_stage dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .funct3(funct3), .funct7(funct7), .op(op),
      .width_32(width_32), .use_imm(use_imm), .is_load(is_load), .is_store(is_store), .is_jump(is_jump),
      .is_branch(is_branch), .add_operation(add_operation), .illegal(illegal)
   );
   assign act = {out_pc, imm, op, funct3, funct7, rs1, rs2, rd,
                 width_32, use_imm, is_load, is_store, is_jump, is_branch, add_operation, illegal};
   // flags: {width_32, use_imm, is_load, is_store, is_jump, is_branch, add_operation, illegal}
   function automatic decode_bundle_t mk(input logic [63:0] pc, input logic [63:0] im, input logic [6:0] o,
                                         input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [4:0] dd, input logic [7:0] fl);
      return {pc, im, o, f3, f7, s1, s2, dd, fl};
   endfunction
   function automatic decode_bundle_t bad(input logic [63:0] pc, input logic [6:0] o);
      return mk(pc, 64'h0, o, 3'b0, 7'b0, 5'd0, 5'd0, 5'd0, 8'h01);
   endfunction
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask
   task automatic send(input logic [31:0] inst, input decode_bundle_t e, input bit track);
      bit acc;
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = e.pc;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            if (track) sb.push_back(e);
            in_valid = 1'b0;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout pc=%0h", e.pc);
      in_valid = 1'b0;
   endtask
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            if (out_ready) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output pc=%0h op=%0h", out_pc, op);
            end
         end else begin
            n_checks++;
            if (act !== sb[0]) begin
               n_fail++;
               $display("FAIL bundle pc=%0h got=%h want=%h", sb[0].pc, act, sb[0]);
            end
            if (out_ready) begin
               void'(sb.pop_front());
               pops++;
            end
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_pc", out_pc, 0);
      chk("post_rst_imm", imm, 0);
      chk("post_rst_rd", rd, 0);
      send(32'h00500093, mk(64'h1000, 64'd5, 7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 8'h40), 1);
      chk("latency_valid", out_valid, 1);
      send(32'h4210D113, mk(64'h1004, 64'd33, 7'h13, 3'b101, 7'h20, 5'd1, 5'd0, 5'd2, 8'h40), 1);
      send(32'h4210D11B, bad(64'h1008, 7'h1B), 1);
      send(32'hFE000EE3, mk(64'h100C, 64'hFFFF_FFFF_FFFF_FFFC, 7'h63, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 8'h04), 1);
`ifdef DECODE_M_EXT_EN
      send(32'h022081BB, mk(64'h1010, 64'd0, 7'h3B, 3'b000, 7'h01, 5'd1, 5'd2, 5'd3, 8'h80), 1);
`else
      send(32'h022081BB, bad(64'h1010, 7'h3B), 1);
`endif
      send(32'h123452B7, mk(64'h1014, 64'h1234_5000, 7'h37, 3'b101, 7'h00, 5'd0, 5'd0, 5'd5, 8'h42), 1);
      send(32'hFE63AC23, mk(64'h1018, 64'hFFFF_FFFF_FFFF_FFF8, 7'h23, 3'b010, 7'h00, 5'd7, 5'd6, 5'd0, 8'h50), 1);
      send(32'h008000EF, mk(64'h101C, 64'd8, 7'h6F, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 8'h08), 1);
      send(32'h00008067, mk(64'h1020, 64'd0, 7'h67, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 8'h48), 1);
      send(32'h0000007F, bad(64'h1024, 7'h7F), 1);
      send(32'h01013503, mk(64'h1028, 64'd16, 7'h03, 3'b011, 7'h00, 5'd2, 5'd0, 5'd10, 8'h60), 1);
      send(32'h402081B3, mk(64'h102C, 64'd0, 7'h33, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 8'h00), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("drain_directed", sb.size(), 0);
      out_ready = 1'b0;
      send(32'h00500093, mk(64'h2000, 64'd5, 7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 8'h40), 1);
      send(32'h402081B3, mk(64'h2004, 64'd0, 7'h33, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 8'h00), 1);
      in_valid = 1'b1;
      in_inst  = 32'hFE000EE3;
      in_pc    = 64'h2008;
      @(negedge clk);
      chk("bp_in_ready_full", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("bp_still_full", in_ready, 0);
      chk("bp_head_pc", out_pc, 64'h2000);
      p0 = pops;
      out_ready = 1'b1;
      send(32'hFE000EE3, mk(64'h2008, 64'hFFFF_FFFF_FFFF_FFFC, 7'h63, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 8'h04), 1);
      @(posedge clk);
      #1;
      chk("bp_burst_pops", pops - p0, 3);
      chk("bp_burst_empty", out_valid, 0);
      out_ready = 1'b0;
      send(32'h00500093, mk(64'h3000, 64'd5, 7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 8'h40), 0);
      send(32'h00500093, mk(64'h3004, 64'd5, 7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 8'h40), 0);
      in_valid = 1'b1;
      in_inst  = 32'h00500093;
      in_pc    = 64'h3008;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send(32'h00500093, mk(64'h4000, 64'd5, 7'h13, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 8'h40), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("post_flush_drain", sb.size(), 0);
      out_ready = 1'b0;
      send(32'h402081B3, mk(64'h5000, 64'd0, 7'h33, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 8'h00), 0);
      send(32'h402081B3, mk(64'h5004, 64'd0, 7'h33, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 8'h00), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_reset_valid", out_valid, 0);
      chk("stall_reset_pc", out_pc, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("stall_reset_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
